// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  typedef enum logic {PRIO0, PRIO1} wb_prio_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester handshakes, regfile write port and read-port fronting.
interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          freeze;
  logic          valid0, valid1;
  logic          ready0, ready1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] qa1, qa2;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic [DW-1:0] qd1, qd2;
  logic [15:0]   collisions;

  modport slave (
    input  freeze, valid0, valid1, addr0, addr1, data0, data1, qa1, qa2, rd1, rd2,
    output ready0, ready1, we3, wa3, wd3, ra1, ra2, qd1, qd2, collisions
  );

  modport master (
    output freeze, valid0, valid1, addr0, addr1, data0, data1, qa1, qa2, rd1, rd2,
    input  ready0, ready1, we3, wa3, wd3, ra1, ra2, qd1, qd2, collisions
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; the loser of an accepted tie gets priority next.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  wb_prio_t state;

  always_comb begin
    gnt0 = !reset && !freeze && valid0 && (state == PRIO0 || !valid1);
    gnt1 = !reset && !freeze && valid1 && (state == PRIO1 || !valid0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRIO0;
    end else if (gnt0 && valid1) begin
      state <= PRIO1;
    end else if (gnt1 && valid0) begin
      state <= PRIO0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the regfile write port and fronts the read ports.
// Build option: define REGFILE_WB_BYPASS_EN to forward the in-flight write to readers.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic          gnt0, gnt1;
  logic          vld_p0;
  wb_req_t       req_p0;
  logic          we3_p1;
  logic [AW-1:0] wa3_p1;
  logic [DW-1:0] wd3_p1;
  logic [15:0]   coll_cnt;

  wb_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .freeze (bus.freeze),
    .valid0 (bus.valid0),
    .valid1 (bus.valid1),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign bus.ready0 = gnt0;
  assign bus.ready1 = gnt1;

  always_comb begin
    vld_p0      = gnt0 || gnt1;
    req_p0.addr = gnt1 ? bus.addr1 : bus.addr0;
    req_p0.data = gnt1 ? bus.data1 : bus.data0;
  end

  // ---- p0 -> p1: register the accepted write onto the regfile port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_p1   <= 1'b0;
      wa3_p1   <= '0;
      wd3_p1   <= '0;
      coll_cnt <= '0;
    end else begin
      // $0 completes the handshake but never raises the write enable
      we3_p1 <= vld_p0 && (req_p0.addr != ZERO_REG);
      if (vld_p0) begin
        wa3_p1 <= req_p0.addr;
        wd3_p1 <= req_p0.data;
      end
      if (bus.valid0 && bus.valid1 && !bus.freeze) begin
        coll_cnt <= sat_inc(coll_cnt);
      end
    end
  end

  assign bus.we3        = we3_p1;
  assign bus.wa3        = wa3_p1;
  assign bus.wd3        = wd3_p1;
  assign bus.collisions = coll_cnt;
  assign bus.ra1        = bus.qa1;
  assign bus.ra2        = bus.qa2;

`ifdef REGFILE_WB_BYPASS_EN
  assign bus.qd1 = (we3_p1 && wa3_p1 == bus.qa1 && bus.qa1 != ZERO_REG) ? wd3_p1 : bus.rd1;
  assign bus.qd2 = (we3_p1 && wa3_p1 == bus.qa2 && bus.qa2 != ZERO_REG) ? wd3_p1 : bus.rd2;
`else
  assign bus.qd1 = bus.rd1;
  assign bus.qd2 = bus.rd2;
`endif

`ifndef SYNTHESIS
  // A refused requester must keep its request up until it is accepted.
  a_hold0: assert property (@(posedge clk) disable iff (reset)
    (bus.valid0 && !bus.ready0) |=> bus.valid0);
  a_hold1: assert property (@(posedge clk) disable iff (reset)
    (bus.valid1 && !bus.ready1) |=> bus.valid1);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, corner sequences and a randomized reference model.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rf_clr;
  int   errors;
  int   checks;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural register file behind the arbiter
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (bus.we3) begin
      rf[bus.wa3] <= bus.wd3;
    end
  end
  assign bus.rd1 = (bus.ra1 == 5'd0) ? 32'd0 : rf[bus.ra1];
  assign bus.rd2 = (bus.ra2 == 5'd0) ? 32'd0 : rf[bus.ra2];

  typedef struct {
    logic        fr, v0, v1;
    logic [4:0]  a0, a1;
    logic        r0, r1, we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic v0, input logic v1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.freeze = fr;
    bus.valid0 = v0;
    bus.valid1 = v1;
    bus.addr0  = a0;
    bus.addr1  = a1;
    bus.data0  = d0;
    bus.data1  = d1;
  endtask

  // reference model state for the randomized phase
  int          pri;
  int          win;
  logic        h0, h1, v0, v1, fr;
  logic [4:0]  a0, a1, q1, q2;
  logic [31:0] d0, d1;
  logic        ewe;
  logic [4:0]  ewa;
  logic [31:0] ewd;
  logic [15:0] ecol;
  logic [31:0] mem [32];
  logic [31:0] eq1, eq2;

  initial begin
    errors = 0;
    checks = 0;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000003};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB0000004};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000003};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd3, 32'hA0000003};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB0000004};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000003};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 5'd3, 32'hA0000003};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'hA0000000};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB0000004};

    // Reset with both requesters valid
    reset  = 1'b1;
    rf_clr = 1'b1;
    bus.qa1 = 5'd0;
    bus.qa2 = 5'd0;
    drive(1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready0", bus.ready0, 1'b0);
    chk1("rst_ready1", bus.ready1, 1'b0);
    chk1("rst_we3", bus.we3, 1'b0);
    chk("rst_wa3", 32'(bus.wa3), 32'd0);
    chk("rst_wd3", bus.wd3, 32'd0);
    chk("rst_coll", 32'(bus.collisions), 32'd0);
    reset  = 1'b0;
    rf_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);

    // Single write and read-back latency
    drive(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    #1;
    chk1("t1_ready0", bus.ready0, 1'b1);
    chk1("t1_ready1", bus.ready1, 1'b0);
    tick();
    chk1("t1_we3", bus.we3, 1'b1);
    chk("t1_wa3", 32'(bus.wa3), 32'd5);
    chk("t1_wd3", bus.wd3, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.qa1 = 5'd5;
    #1;
    chk("t1_qd1_n1", bus.qd1, BYP ? 32'hDEADBEEF : 32'd0);
    tick();
    chk("t1_qd1_n2", bus.qd1, 32'hDEADBEEF);

    // Four-cycle tie alternates grants, then the pending port 0 drains
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22);
      #1;
      chk1("t2_ready0", bus.ready0, (k % 2) == 0);
      chk1("t2_ready1", bus.ready1, (k % 2) == 1);
      tick();
      chk("t2_wa3", 32'(bus.wa3), ((k % 2) == 0) ? 32'd1 : 32'd2);
    end
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22);
    #1;
    chk1("t2_tail_ready0", bus.ready0, 1'b1);
    tick();
    chk("t2_coll", 32'(bus.collisions), 32'd4);

    // Write to $0: accepted but no write enable
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'h1234);
    bus.qa1 = 5'd0;
    #1;
    chk1("t3_ready1", bus.ready1, 1'b1);
    chk("t3_qd1_zero", bus.qd1, 32'd0);
    tick();
    chk1("t3_we3", bus.we3, 1'b0);
    chk("t3_qd1_zero_after", bus.qd1, 32'd0);

    // Freeze for three cycles with both valid
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 32'h33, 32'h44);
      #1;
      chk1("t4_frz_ready0", bus.ready0, 1'b0);
      chk1("t4_frz_ready1", bus.ready1, 1'b0);
      chk1("t4_frz_we3", bus.we3, 1'b0);
      tick();
    end
    chk1("t4_post_we3", bus.we3, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 32'h33, 32'h44);
    #1;
    chk1("t4_rel_ready0", bus.ready0, 1'b1);
    chk1("t4_rel_ready1", bus.ready1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd3, 5'd4, 32'h33, 32'h44);
    #1;
    chk1("t4_drain_ready1", bus.ready1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    chk("t4_coll", 32'(bus.collisions), 32'd5);

    // Bypass window: read one cycle after accept
    drive(1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 32'hA5A5A5A5, 32'd0);
    #1;
    chk1("t5_ready0", bus.ready0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    bus.qa2 = 5'd7;
    #1;
    chk("t5_qd2_n1", bus.qd2, BYP ? 32'hA5A5A5A5 : 32'd0);
    tick();
    chk("t5_qd2_n2", bus.qd2, 32'hA5A5A5A5);

    // Table-driven vectors from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].fr, tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1,
            32'hA0000000 | 32'(tbl[i].a0), 32'hB0000000 | 32'(tbl[i].a1));
      #1;
      chk1($sformatf("vec%0d_ready0", i), bus.ready0, tbl[i].r0);
      chk1($sformatf("vec%0d_ready1", i), bus.ready1, tbl[i].r1);
      tick();
      chk1($sformatf("vec%0d_we3", i), bus.we3, tbl[i].we);
      chk($sformatf("vec%0d_wa3", i), 32'(bus.wa3), 32'(tbl[i].wa));
      chk($sformatf("vec%0d_wd3", i), bus.wd3, tbl[i].wd);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    chk("vec_coll", 32'(bus.collisions), 32'd3);

    // Reset in the cycle after an accept
    drive(1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 32'h99, 32'd0);
    #1;
    chk1("t6_ready0", bus.ready0, 1'b1);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd6, 32'd0, 32'h66);
    #1;
    chk1("t6_rst_ready0", bus.ready0, 1'b0);
    chk1("t6_rst_ready1", bus.ready1, 1'b0);
    chk1("t6_inflight_we3", bus.we3, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd6, 32'h99, 32'h66);
    #1;
    chk1("t6_we3", bus.we3, 1'b0);
    chk("t6_wa3", 32'(bus.wa3), 32'd0);
    chk("t6_coll", 32'(bus.collisions), 32'd0);
    chk1("t6_prio_ready0", bus.ready0, 1'b1);
    chk1("t6_prio_ready1", bus.ready1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd9, 5'd6, 32'h99, 32'h66);
    #1;
    chk1("t6_drain_ready1", bus.ready1, 1'b1);
    tick();

    // Randomized traffic against the reference model
    reset  = 1'b1;
    rf_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    reset  = 1'b0;
    rf_clr = 1'b0;
    pri = 0;
    h0 = 1'b0; h1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = 5'd0; a1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
    ewe = 1'b0; ewa = 5'd0; ewd = 32'd0; ecol = 16'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    for (int c = 0; c < 400; c++) begin
      chk1("rnd_we3", bus.we3, ewe);
      chk("rnd_wa3", 32'(bus.wa3), 32'(ewa));
      chk("rnd_wd3", bus.wd3, ewd);
      chk("rnd_coll", 32'(bus.collisions), 32'(ecol));

      fr = ($urandom_range(0, 3) == 0);
      if (!h0) begin
        v0 = ($urandom_range(0, 2) != 0);
        a0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!h1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      q1 = ($urandom_range(0, 1) == 1) ? ewa : 5'($urandom_range(0, 31));
      q2 = ($urandom_range(0, 1) == 1) ? ewa : 5'($urandom_range(0, 31));
      drive(fr, v0, v1, a0, a1, d0, d1);
      bus.qa1 = q1;
      bus.qa2 = q2;
      #1;

      if (fr) win = -1;
      else if (v0 && v1) win = pri;
      else if (v0) win = 0;
      else if (v1) win = 1;
      else win = -1;
      chk1("rnd_ready0", bus.ready0, win == 0);
      chk1("rnd_ready1", bus.ready1, win == 1);

      eq1 = (BYP && ewe && ewa == q1 && q1 != 5'd0) ? ewd : mem[q1];
      eq2 = (BYP && ewe && ewa == q2 && q2 != 5'd0) ? ewd : mem[q2];
      chk("rnd_qd1", bus.qd1, eq1);
      chk("rnd_qd2", bus.qd2, eq2);

      if (ewe) mem[ewa] = ewd;
      if (v0 && v1 && !fr && ecol != 16'hFFFF) ecol = ecol + 16'd1;
      if (win == 0) begin
        ewe = (a0 != 5'd0); ewa = a0; ewd = d0;
      end else if (win == 1) begin
        ewe = (a1 != 5'd0); ewa = a1; ewd = d1;
      end else begin
        ewe = 1'b0;
      end
      if (v0 && v1 && win >= 0) pri = 1 - win;
      h0 = v0 && (win != 0);
      h1 = v1 && (win != 1);

      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 MIPS register file (`we3`/`wa3`/`wd3`) between two writeback requesters: the ALU writeback path (port 0) and the multicycle/memory unit (port 1). It runs a two-way round-robin over valid/ready handshakes and registers the winning write onto the regfile port. It also fronts both regfile read ports so that reads can be forwarded from the in-flight write. It sits between the datapath writeback stage and `regfile`.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `freeze`  in  1  hazard-unit stall; no grants while high.
- `valid0`, `valid1`  in  1  requester has a write pending.
- `ready0`, `ready1`  out  1  combinational grant; a write is accepted when `validN && readyN`.
- `addr0`, `addr1`  in  AW  destination register.
- `data0`, `data1`  in  DW  write data.
- `we3`  out  1  regfile write enable (registered).
- `wa3`  out  AW  regfile write address (registered).
- `wd3`  out  DW  regfile write data (registered).
- `qa1`, `qa2`  in  AW  consumer read addresses.
- `ra1`, `ra2`  out  AW  regfile read addresses; `qa1`/`qa2` passed through combinationally.
- `rd1`, `rd2`  in  DW  regfile read data.
- `qd1`, `qd2`  out  DW  read data returned to consumers.
- `collisions`  out  16  saturating count of cycles in which both requesters were valid and not frozen.

## Operation
- Priority FSM states:
  - `PRIO0`: port 0 wins ties. Reset state.
  - `PRIO1`: port 1 wins ties.
- Grant rule (combinational):
  - `ready0 = !freeze && valid0 && (state==PRIO0 || !valid1)`.
  - `ready1 = !freeze && valid1 && (state==PRIO1 || !valid0)`.
  - At most one ready is high in any cycle.
- FSM transitions: on an accepted tie, move to the loser's priority state (grant from `PRIO0` → `PRIO1`, and vice versa). A grant with a single valid requester, or no grant, leaves the state unchanged.
- Output register on accept: `wa3 <= addrN`, `wd3 <= dataN`, `we3 <= (addrN != 0)`.
  - A write to `$0` is accepted (handshake completes) but `we3` stays 0.
  - With no accept, `we3 <= 0`; `wa3`/`wd3` hold their values.
- Read path: `ra1=qa1`, `ra2=qa2`, `qd1=rd1`, `qd2=rd2`, except as modified under Configuration.
- `collisions` increments when `valid0 && valid1 && !freeze` and saturates at 0xFFFF.

## Timing
- Reset values: `we3=0`, `wa3=0`, `wd3=0`, `collisions=0`, state=`PRIO0`.
  - `ready0`/`ready1` are 0 while `reset` is high.
  - A handshake in the same cycle as `reset` is discarded.
- Latency: accept in cycle N → `we3` high during cycle N+1 → register written at the end of N+1 → `rd*` reflects the new value in N+2.
- `freeze` forces both readies low that cycle. A write already in the output register still completes. Requesters must hold `addr`/`data` stable while valid and not ready.
- Back-to-back accepts are allowed every cycle; throughput is one write per cycle.
- Same-cycle `valid` drop: the requester may deassert `valid` only after an accept. Deassertion without an accept is a protocol error and is flagged by an assertion.

## Configuration
- Macro: `REGFILE_WB_BYPASS_EN`.
- Defined:
  - `qd1 = (we3 && wa3==qa1 && qa1!=0) ? wd3 : rd1`; `qd2` is formed likewise.
  - This gives consumers the in-flight value one cycle earlier, so a read in cycle N+1 sees the write accepted in cycle N.
- Undefined: `qd1=rd1`, `qd2=rd2`. Consumers see the value at N+2.
- `$0` always reads the regfile value (0) in both builds.

## Structure
- `regfile_pkg` holds:
  - constants `REG_AW=5`, `REG_DW=32`, `ZERO_REG=5'd0`;
  - `typedef struct packed {logic [REG_AW-1:0] addr; logic [REG_DW-1:0] data;} wb_req_t`;
  - `typedef enum logic {PRIO0, PRIO1} wb_prio_t`.
- One sub-module, `wb_rr_arb2`: the two-way round-robin grant logic plus the FSM (inputs: valids, freeze; outputs: grants).
- The output register, bypass mux and counter live in `regfile_wb_arbiter`.

## Test plan
- Reset, then `valid0=1`, `addr0=5`, `data0=0xDEADBEEF` → `ready0=1` in cycle 0. In cycle 1: `we3=1`, `wa3=5`, `wd3=0xDEADBEEF`. In cycle 2: `qa1=5` returns 0xDEADBEEF.
- Both valid for 4 cycles (`addr0=1`, `addr1=2`) → grant order 0,1,0,1 starting from `PRIO0`; `collisions=4`.
- `valid1=1`, `addr1=0`, `data1=0x1234` → `ready1=1` and `we3` stays 0; `qa1=0` returns 0.
- `freeze=1` for 3 cycles with both valid → both readies low and `we3=0` in every frozen cycle. After release, port 0 is granted first (state unchanged).
- `REGFILE_WB_BYPASS_EN`: accept `addr0=7`, `data0=0xA5A5A5A5` in cycle N, with `qa2=7` in N+1 → `qd2=0xA5A5A5A5` in N+1. Without the macro, `qd2` shows the old value in N+1.
- Assert `reset` in the cycle after an accept → `we3=0` next cycle, state returns to `PRIO0`, and `collisions=0`.
